dtc_walker: RTL and testbench
=============================

# dtc_walker

Sequential, programmable decision-tree classifier: a parametrised successor to the fixed combinational trees in the decision-tree classifier set.
- Holds the tree in a run-time writable node table.
- Accepts one feature vector at a time over a valid/ready handshake.
- Walks the tree one node per clock and returns the leaf class value with an error flag.
- Sits between the feature front-end and the result collector, so one netlist can serve any tree that fits NODES/IN_W/OUT_W.

## Interface
- IN_W, 8, feature vector width (bits tested by internal nodes)
- OUT_W, 7, leaf class value width
- NODES, 32, node table depth; AW = $clog2(NODES), FW = $clog2(IN_W)
- MAX_DEPTH, 16, walk-step limit (used only with the depth guard)
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  feature vector offered
- in_ready  out  1  high only in IDLE
- in_data  in  IN_W  feature vector
- out_valid  out  1  result held until accepted
- out_ready  in  1  result consumer ready
- out_data  out  OUT_W  class value
- out_err  out  1  walk aborted (bad pointer or depth guard)
- cfg_we  in  1  node write strobe
- cfg_ready  out  1  high only in IDLE; writes with cfg_ready low are dropped
- cfg_addr  in  AW  node index
- cfg_data  in  NW  node word, NW = 1+FW+2*AW+OUT_W

## Operation
- Node word fields, MSB to LSB:
  - inner (1 = internal node, 0 = leaf)
  - feat[FW]
  - t_child[AW]
  - f_child[AW]
  - value[OUT_W]
- Internal node: next = in_data_q[feat] ? t_child : f_child. Leaf: result = value.
- Root is node 0. Reset clears every table word to zero, i.e. a leaf with value 0.
- FSM states:
  - IDLE: in_ready = cfg_ready = 1. in_valid latches in_data_q, sets ptr = 0 and step = 0, then goes to WALK.
  - WALK: reads node[ptr] combinationally each cycle.
    - Leaf: load out_data = value, out_err = 0, go to DONE.
    - Internal node with selected child >= NODES: out_data = 0, out_err = 1, go to DONE.
    - Otherwise: ptr = child, step++.
  - DONE: out_valid = 1 and outputs held stable. On out_ready, go to IDLE.
- cfg_addr >= NODES: write ignored.
- cfg_we and in_valid accepted on the same IDLE edge: the write lands first, and the walk sees the updated table.
- feat >= IN_W: the bit reads as 0.

## Timing
- Reset values:
  - in_ready = 1, cfg_ready = 1
  - out_valid = 0, out_data = 0, out_err = 0
  - state = IDLE; table all zero
- Latency: for a leaf at depth d (d internal nodes traversed), out_valid rises d+1 cycles after the accepting edge.
- Throughput: no overlap. The next input is accepted earliest on the cycle after the out_valid & out_ready edge, giving d+3 cycles per item minimum.
- out_valid never drops without out_ready.
- rst_n asserted mid-walk or in DONE: immediate return to reset values. The in-flight result is lost and the table is cleared.

## Configuration
- DTC_DEPTH_GUARD_EN defined:
  - A step counter of $clog2(MAX_DEPTH+1) bits is built.
  - When step reaches MAX_DEPTH in WALK without reaching a leaf: out_data = 0, out_err = 1, go to DONE.
  - Worst-case latency is therefore MAX_DEPTH+1.
- Not defined:
  - No counter is built; MAX_DEPTH is unused.
  - A cyclic table walks forever; only reset recovers.
  - out_err is raised only by a bad pointer.

## Structure
- Package dtc_pkg holds:
  - State enum (IDLE, WALK, DONE).
  - Field-offset/width functions of (IN_W, OUT_W, NODES) for NW, inner, feat, t_child, f_child, value.
- Sub-module dtc_node_table: NODES×NW flop array, async-reset to zero, one write port (we/addr/data with range check), one combinational read port.
- dtc_walker holds the FSM, input and pointer registers, the optional step counter, and the output registers.

## Test plan
All scenarios use default parameters unless stated.
- Reset, empty table, inp 8'hFF accepted -> out_valid one cycle later, out_data 7'h00, out_err 0.
- Program node0 = {inner, feat 7, t 2, f 1}, node1 = leaf 7'h5B, node2 = leaf 7'h37:
  - inp 8'h80 -> 7'h37 after 2 cycles.
  - inp 8'h00 -> 7'h5B after 2 cycles.
- Backpressure: hold out_ready = 0 for 5 cycles -> out_data/out_valid stable, in_ready = cfg_ready = 0, offered input and cfg writes ignored. Raise out_ready -> in_ready high the next cycle.
- node0 = {inner, t 0, f 0}, MAX_DEPTH = 8, guard on -> out_err = 1, out_data = 0 at 9 cycles. Guard off -> no out_valid within 100 cycles. rst_n pulse mid-walk -> all reset values, node0 reads zero.
- NODES = 12, node0 = {inner, feat 0, t 13, f 1}, inp 8'h01 -> out_err = 1 after 1 cycle. Write to cfg_addr 12 -> table unchanged.
- Same IDLE edge: cfg_we writes node0 = leaf 7'h21 and in_valid is asserted -> out_data 7'h21 after 1 cycle.

Source files
------------

// File: rtl/dtc_pkg.sv
// Shared types and node-word field layout for the dtc_walker decision-tree classifier.
package dtc_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WALK = 2'd1,
        DONE = 2'd2
    } state_e;

    function automatic int dtc_aw(input int nodes);
        return (nodes > 1) ? $clog2(nodes) : 1;
    endfunction

    function automatic int dtc_fw(input int in_w);
        return (in_w > 1) ? $clog2(in_w) : 1;
    endfunction

    function automatic int dtc_nw(input int in_w, input int out_w, input int nodes);
        return 1 + dtc_fw(in_w) + 2 * dtc_aw(nodes) + out_w;
    endfunction

    // Node word layout, MSB to LSB: inner, feat, t_child, f_child, value
    localparam int DTC_VALUE_LSB = 0;

    function automatic int dtc_f_lsb(input int out_w);
        return out_w;
    endfunction

    function automatic int dtc_t_lsb(input int out_w, input int nodes);
        return out_w + dtc_aw(nodes);
    endfunction

    function automatic int dtc_feat_lsb(input int out_w, input int nodes);
        return out_w + 2 * dtc_aw(nodes);
    endfunction

    function automatic int dtc_inner_bit(input int in_w, input int out_w, input int nodes);
        return dtc_nw(in_w, out_w, nodes) - 1;
    endfunction

endpackage

// File: rtl/dtc_node_table.sv
// Run-time writable node table: NODES x NW flops, one range-checked write port, one async read port.
module dtc_node_table #(
    parameter int NODES = 32,
    parameter int NW    = 21,
    parameter int AW    = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we,
    input  logic [AW-1:0] wr_addr,
    input  logic [NW-1:0] wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [NW-1:0] rd_data
);

    logic [NW-1:0] mem_q [NODES];
    logic [NW-1:0] mem_d [NODES];

    always_comb begin
        mem_d = mem_q;
        if (we && (int'(wr_addr) < NODES)) begin
            mem_d[wr_addr] = wr_data;
        end
    end

    // Cleared table is all leaves of class 0, so an unprogrammed tree still answers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NODES; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    assign rd_data = (int'(rd_addr) < NODES) ? mem_q[rd_addr] : '0;

endmodule

// File: rtl/dtc_walker.sv
// Sequential decision-tree classifier walking one node per clock.
// Optional walk-step limit enabled by defining DTC_DEPTH_GUARD_EN.
module dtc_walker
    import dtc_pkg::*;
#(
    parameter int IN_W      = 8,
    parameter int OUT_W     = 7,
    parameter int NODES     = 32,
    parameter int MAX_DEPTH = 16,
    localparam int AW       = dtc_aw(NODES),
    localparam int FW       = dtc_fw(IN_W),
    localparam int NW       = dtc_nw(IN_W, OUT_W, NODES)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             out_err,
    input  logic             cfg_we,
    output logic             cfg_ready,
    input  logic [AW-1:0]    cfg_addr,
    input  logic [NW-1:0]    cfg_data
);

    localparam int INNER_BIT = dtc_inner_bit(IN_W, OUT_W, NODES);
    localparam int FEAT_LSB  = dtc_feat_lsb(OUT_W, NODES);
    localparam int T_LSB     = dtc_t_lsb(OUT_W, NODES);
    localparam int F_LSB     = dtc_f_lsb(OUT_W);

    if (MAX_DEPTH < 1) begin : g_bad_max_depth
        $error("dtc_walker: MAX_DEPTH must be at least 1");
    end

    state_e            state_q, state_d;
    logic [IN_W-1:0]   in_data_q, in_data_d;
    logic [AW-1:0]     ptr_q, ptr_d;
    logic [OUT_W-1:0]  out_data_q, out_data_d;
    logic              out_err_q, out_err_d;

    logic [NW-1:0]     node;
    logic              node_inner;
    logic [FW-1:0]     node_feat;
    logic [AW-1:0]     node_child;
    logic [OUT_W-1:0]  node_value;
    logic              feat_bit;
    logic              child_bad;
    logic              depth_hit;
    logic              start;
    logic              advance;

    assign in_ready  = (state_q == IDLE);
    assign cfg_ready = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign out_data  = out_data_q;
    assign out_err   = out_err_q;

    dtc_node_table #(
        .NODES (NODES),
        .NW    (NW),
        .AW    (AW)
    ) u_table (
        .clk     (clk),
        .rst_n   (rst_n),
        .we      (cfg_we && cfg_ready),
        .wr_addr (cfg_addr),
        .wr_data (cfg_data),
        .rd_addr (ptr_q),
        .rd_data (node)
    );

    assign node_inner = node[INNER_BIT];
    assign node_feat  = node[FEAT_LSB +: FW];
    assign node_value = node[DTC_VALUE_LSB +: OUT_W];
    assign feat_bit   = (int'(node_feat) < IN_W) ? in_data_q[node_feat] : 1'b0;
    assign node_child = feat_bit ? node[T_LSB +: AW] : node[F_LSB +: AW];
    assign child_bad  = (int'(node_child) >= NODES);
    assign start      = (state_q == IDLE) && in_valid;
    assign advance    = (state_q == WALK) && node_inner && !depth_hit && !child_bad;

`ifdef DTC_DEPTH_GUARD_EN
    localparam int SW = $clog2(MAX_DEPTH + 1);

    logic [SW-1:0] step_q, step_d;

    always_comb begin
        step_d = step_q;
        if (start) begin
            step_d = '0;
        end else if (advance) begin
            step_d = step_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            step_q <= '0;
        end else begin
            step_q <= step_d;
        end
    end

    assign depth_hit = (step_q == SW'(MAX_DEPTH));
`else
    assign depth_hit = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        in_data_d  = in_data_q;
        ptr_d      = ptr_q;
        out_data_d = out_data_q;
        out_err_d  = out_err_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    in_data_d = in_data;
                    ptr_d     = '0;
                    state_d   = WALK;
                end
            end
            WALK: begin
                if (!node_inner) begin
                    out_data_d = node_value;
                    out_err_d  = 1'b0;
                    state_d    = DONE;
                end else if (!advance) begin
                    out_data_d = '0;
                    out_err_d  = 1'b1;
                    state_d    = DONE;
                end else begin
                    ptr_d = node_child;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            in_data_q  <= '0;
            ptr_q      <= '0;
            out_data_q <= '0;
            out_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            in_data_q  <= in_data_d;
            ptr_q      <= ptr_d;
            out_data_q <= out_data_d;
            out_err_q  <= out_err_d;
        end
    end

endmodule

// File: tb/tb_dtc_walker.sv
// Scoreboard bench for dtc_walker: a 32-node instance (MAX_DEPTH 8) and a 12-node instance.
// Depth-guard expectations follow DTC_DEPTH_GUARD_EN.
module tb_dtc_walker;

    typedef struct {
        logic [6:0] data;
        logic       err;
        int         due;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        out_ready;

    logic        a_in_valid, a_in_ready, a_out_valid, a_out_err, a_cfg_we, a_cfg_ready;
    logic [7:0]  a_in_data;
    logic [6:0]  a_out_data;
    logic [4:0]  a_cfg_addr;
    logic [20:0] a_cfg_data;

    logic        b_in_valid, b_in_ready, b_out_valid, b_out_err, b_cfg_we, b_cfg_ready;
    logic [7:0]  b_in_data;
    logic [6:0]  b_out_data;
    logic [3:0]  b_cfg_addr;
    logic [18:0] b_cfg_data;

    exp_t q_a[$];
    exp_t q_b[$];
    exp_t mon_e;
    int   n_vec;
    int   n_miss;
    int   cyc;
    logic a_prev_v;
    logic b_prev_v;

    dtc_walker #(.IN_W(8), .OUT_W(7), .NODES(32), .MAX_DEPTH(8)) dut_a (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (a_in_valid),
        .in_ready  (a_in_ready),
        .in_data   (a_in_data),
        .out_valid (a_out_valid),
        .out_ready (out_ready),
        .out_data  (a_out_data),
        .out_err   (a_out_err),
        .cfg_we    (a_cfg_we),
        .cfg_ready (a_cfg_ready),
        .cfg_addr  (a_cfg_addr),
        .cfg_data  (a_cfg_data)
    );

    dtc_walker #(.IN_W(8), .OUT_W(7), .NODES(12), .MAX_DEPTH(16)) dut_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (b_in_valid),
        .in_ready  (b_in_ready),
        .in_data   (b_in_data),
        .out_valid (b_out_valid),
        .out_ready (out_ready),
        .out_data  (b_out_data),
        .out_err   (b_out_err),
        .cfg_we    (b_cfg_we),
        .cfg_ready (b_cfg_ready),
        .cfg_addr  (b_cfg_addr),
        .cfg_data  (b_cfg_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [20:0] nodeA(input bit inner, input int feat, input int t,
                                          input int f, input int v);
        return {inner, 3'(feat), 5'(t), 5'(f), 7'(v)};
    endfunction

    function automatic logic [18:0] nodeB(input bit inner, input int feat, input int t,
                                          input int f, input int v);
        return {inner, 3'(feat), 4'(t), 4'(f), 7'(v)};
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: each rising out_valid is one presented result, checked against the queue head.
    always @(negedge clk) begin
        if (rst_n) begin
            if (a_out_valid && !a_prev_v) begin
                if (q_a.size() == 0) begin
                    n_vec++;
                    n_miss++;
                    $display("[TB] FAIL a_unexpected: got result 0x%0h, expected none", a_out_data);
                end else begin
                    mon_e = q_a.pop_front();
                    checkOutput("a_out_data", 32'(a_out_data), 32'(mon_e.data));
                    checkOutput("a_out_err", 32'(a_out_err), 32'(mon_e.err));
                    checkOutput("a_latency", cyc, mon_e.due);
                end
            end
            if (b_out_valid && !b_prev_v) begin
                if (q_b.size() == 0) begin
                    n_vec++;
                    n_miss++;
                    $display("[TB] FAIL b_unexpected: got result 0x%0h, expected none", b_out_data);
                end else begin
                    mon_e = q_b.pop_front();
                    checkOutput("b_out_data", 32'(b_out_data), 32'(mon_e.data));
                    checkOutput("b_out_err", 32'(b_out_err), 32'(mon_e.err));
                    checkOutput("b_latency", cyc, mon_e.due);
                end
            end
        end
        a_prev_v = a_out_valid;
        b_prev_v = b_out_valid;
    end

    task automatic cfgWrite(input bit which, input int addr, input logic [20:0] data);
        @(negedge clk);
        if (!which) begin
            a_cfg_we   = 1'b1;
            a_cfg_addr = 5'(addr);
            a_cfg_data = data;
        end else begin
            b_cfg_we   = 1'b1;
            b_cfg_addr = 4'(addr);
            b_cfg_data = data[18:0];
        end
        @(posedge clk);
        #1;
        a_cfg_we = 1'b0;
        b_cfg_we = 1'b0;
    endtask

    task automatic applyStimulus(input bit which, input logic [7:0] din, input bit expect_it,
                                 input logic [6:0] ed, input bit ee, input int lat);
        int waited;
        exp_t e;
        waited = 0;
        @(negedge clk);
        while (!(which ? b_in_ready : a_in_ready) && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (!(which ? b_in_ready : a_in_ready)) begin
            n_vec++;
            n_miss++;
            $display("[TB] FAIL accept_timeout: in_ready 0 after %0d cycles, required 1", waited);
        end else begin
            if (!which) begin
                a_in_valid = 1'b1;
                a_in_data  = din;
            end else begin
                b_in_valid = 1'b1;
                b_in_data  = din;
            end
            @(posedge clk);
            #1;
            a_in_valid = 1'b0;
            b_in_valid = 1'b0;
            if (expect_it) begin
                e.data = ed;
                e.err  = ee;
                e.due  = cyc + lat;
                if (!which) q_a.push_back(e);
                else        q_b.push_back(e);
            end
        end
    endtask

    task automatic waitIdle(input bit which);
        int waited;
        waited = 0;
        @(negedge clk);
        while (waited < 200 &&
               !((which ? (q_b.size() == 0) : (q_a.size() == 0)) &&
                 (which ? b_in_ready : a_in_ready))) begin
            @(negedge clk);
            waited++;
        end
        if (waited >= 200) begin
            n_vec++;
            n_miss++;
            $display("[TB] FAIL idle_timeout: result pending after %0d cycles, required done", waited);
        end
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bit seen;
        n_vec      = 0;
        n_miss     = 0;
        a_prev_v   = 1'b0;
        b_prev_v   = 1'b0;
        rst_n      = 1'b0;
        out_ready  = 1'b1;
        a_in_valid = 1'b0;
        a_in_data  = '0;
        a_cfg_we   = 1'b0;
        a_cfg_addr = '0;
        a_cfg_data = '0;
        b_in_valid = 1'b0;
        b_in_data  = '0;
        b_cfg_we   = 1'b0;
        b_cfg_addr = '0;
        b_cfg_data = '0;

        repeat (2) @(negedge clk);
        checkOutput("rst_in_ready", 32'(a_in_ready), 32'd1);
        checkOutput("rst_cfg_ready", 32'(a_cfg_ready), 32'd1);
        checkOutput("rst_out_valid", 32'(a_out_valid), 32'd0);
        checkOutput("rst_out_data", 32'(a_out_data), 32'd0);
        checkOutput("rst_out_err", 32'(a_out_err), 32'd0);
        rst_n = 1'b1;

        $display("[TB] empty table");
        applyStimulus(0, 8'hFF, 1, 7'h00, 0, 1);
        waitIdle(0);

        $display("[TB] three-node tree");
        cfgWrite(0, 0, nodeA(1, 7, 2, 1, 0));
        cfgWrite(0, 1, nodeA(0, 0, 0, 0, 'h5B));
        cfgWrite(0, 2, nodeA(0, 0, 0, 0, 'h37));
        applyStimulus(0, 8'h80, 1, 7'h37, 0, 2);
        waitIdle(0);
        applyStimulus(0, 8'h00, 1, 7'h5B, 0, 2);
        waitIdle(0);

        $display("[TB] backpressure");
        @(negedge clk);
        out_ready = 1'b0;
        applyStimulus(0, 8'h80, 1, 7'h37, 0, 2);
        begin
            int w;
            w = 0;
            while (!a_out_valid && w < 20) begin
                @(negedge clk);
                w++;
            end
        end
        for (int i = 0; i < 5; i++) begin
            a_in_valid = 1'b1;
            a_in_data  = 8'h00;
            a_cfg_we   = 1'b1;
            a_cfg_addr = 5'd1;
            a_cfg_data = nodeA(0, 0, 0, 0, 'h7F);
            checkOutput("bp_out_valid", 32'(a_out_valid), 32'd1);
            checkOutput("bp_out_data", 32'(a_out_data), 32'h37);
            checkOutput("bp_in_ready", 32'(a_in_ready), 32'd0);
            checkOutput("bp_cfg_ready", 32'(a_cfg_ready), 32'd0);
            @(negedge clk);
        end
        a_in_valid = 1'b0;
        a_cfg_we   = 1'b0;
        out_ready  = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("bp_in_ready_after", 32'(a_in_ready), 32'd1);
        checkOutput("bp_out_valid_after", 32'(a_out_valid), 32'd0);
        applyStimulus(0, 8'h00, 1, 7'h5B, 0, 2);
        waitIdle(0);

        $display("[TB] self-loop");
        cfgWrite(0, 0, nodeA(1, 0, 0, 0, 0));
`ifdef DTC_DEPTH_GUARD_EN
        applyStimulus(0, 8'h01, 1, 7'h00, 1, 9);
        waitIdle(0);
        applyStimulus(0, 8'h01, 0, 7'h00, 0, 0);
        repeat (3) @(negedge clk);
`else
        applyStimulus(0, 8'h01, 0, 7'h00, 0, 0);
        seen = 1'b0;
        repeat (100) begin
            @(negedge clk);
            if (a_out_valid) seen = 1'b1;
        end
        checkOutput("noguard_no_valid", 32'(seen), 32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_in_ready", 32'(a_in_ready), 32'd1);
        checkOutput("midrst_cfg_ready", 32'(a_cfg_ready), 32'd1);
        checkOutput("midrst_out_valid", 32'(a_out_valid), 32'd0);
        checkOutput("midrst_out_data", 32'(a_out_data), 32'd0);
        checkOutput("midrst_out_err", 32'(a_out_err), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(0, 8'hFF, 1, 7'h00, 0, 1);
        waitIdle(0);

        $display("[TB] bad pointer, NODES=12");
        cfgWrite(1, 0, 21'(nodeB(1, 0, 13, 1, 0)));
        cfgWrite(1, 1, 21'(nodeB(0, 0, 0, 0, 'h11)));
        applyStimulus(1, 8'h01, 1, 7'h00, 1, 1);
        waitIdle(1);
        applyStimulus(1, 8'h00, 1, 7'h11, 0, 2);
        waitIdle(1);
        cfgWrite(1, 12, 21'(nodeB(0, 0, 0, 0, 'h7F)));
        applyStimulus(1, 8'h00, 1, 7'h11, 0, 2);
        waitIdle(1);
        applyStimulus(1, 8'h01, 1, 7'h00, 1, 1);
        waitIdle(1);

        $display("[TB] write and accept on same edge");
        @(negedge clk);
        a_cfg_we   = 1'b1;
        a_cfg_addr = 5'd0;
        a_cfg_data = nodeA(0, 0, 0, 0, 'h21);
        a_in_valid = 1'b1;
        a_in_data  = 8'h5A;
        @(posedge clk);
        #1;
        a_cfg_we   = 1'b0;
        a_in_valid = 1'b0;
        mon_e.data = 7'h21;
        mon_e.err  = 1'b0;
        mon_e.due  = cyc + 1;
        q_a.push_back(mon_e);
        waitIdle(0);

        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
